// File: rtl/filter_pkg.sv
// Shared types and helpers for the sequential convolution filter.
// FILTER_SATURATE_EN selects clamping accumulation in filter_seq; the
// sat_add helper below is only called in that build.
package filter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } filter_state_e;

    // Widest accumulator the saturating helper supports.
    localparam int SatMaxWidth = 64;

    typedef struct packed {
        logic signed [SatMaxWidth-1:0] sum;
        logic                          clamp;
    } sat_res_t;

    // Adds two sign-extended operands and clamps the result to a signed
    // range of 'width' bits; clamp reports that the range was exceeded.
    function automatic sat_res_t sat_add(input logic signed [SatMaxWidth-1:0] a,
                                         input logic signed [SatMaxWidth-1:0] b,
                                         input int unsigned                   width);
        logic signed [SatMaxWidth:0] s;
        logic signed [SatMaxWidth:0] hi;
        logic signed [SatMaxWidth:0] lo;
        sat_res_t r;
        s  = {a[SatMaxWidth-1], a} + {b[SatMaxWidth-1], b};
        hi = ((SatMaxWidth+1)'(1) << (width - 1)) - (SatMaxWidth+1)'(1);
        lo = -hi - (SatMaxWidth+1)'(1);
        r.sum   = s[SatMaxWidth-1:0];
        r.clamp = 1'b0;
        if (s > hi) begin
            r.sum   = hi[SatMaxWidth-1:0];
            r.clamp = 1'b1;
        end else if (s < lo) begin
            r.sum   = lo[SatMaxWidth-1:0];
            r.clamp = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/filter_seq_if.sv
// Window-in / result-out bus of filter_seq.
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; valid never waits for ready, ready may depend on the
// downstream ready but never on valid, and the sender holds its payload
// stable while valid is high and ready is low.
// state_o exposes the filter FSM state for observation.
interface filter_seq_if #(
    parameter int WidthIn     = 1,
    parameter int WidthOut    = 32,
    parameter int KernelWidth = 3,
    parameter int WeightWidth = 2,
    parameter int InChannels  = 1,
    parameter int OutChannels = 1
) ();
    import filter_pkg::*;

    localparam int KernelArea = KernelWidth * KernelWidth;

    logic                                                                valid_i;
    logic                                                                ready_o;
    logic [InChannels-1:0][KernelArea-1:0][WidthIn-1:0]                  windows_i;
    logic signed [OutChannels-1:0][InChannels-1:0][KernelArea-1:0][WeightWidth-1:0] weights_i;
    logic                                                                valid_o;
    logic                                                                ready_i;
    logic signed [OutChannels-1:0][WidthOut-1:0]                         data_o;
    logic                                                                sat_o;
    filter_state_e                                                       state_o;

    modport slave (
        input  valid_i, windows_i, weights_i, ready_i,
        output ready_o, valid_o, data_o, sat_o, state_o
    );

    modport master (
        output valid_i, windows_i, weights_i, ready_i,
        input  ready_o, valid_o, data_o, sat_o, state_o
    );

endinterface

// File: rtl/filter_seq_mac.sv
// One kernel-area multiply-accumulate: zero-extended pixels times signed
// weights, summed modulo 2^WidthOut.
module filter_seq_mac #(
    parameter int WidthIn     = 1,
    parameter int WidthOut    = 32,
    parameter int KernelArea  = 9,
    parameter int WeightWidth = 2
) (
    input  logic [KernelArea-1:0][WidthIn-1:0]     window_i,
    input  logic [KernelArea-1:0][WeightWidth-1:0] weights_i,
    output logic signed [WidthOut-1:0]             sum_o
);

    // Extra bit keeps the zero-extended pixel positive in the signed product.
    localparam int ProdW = WidthIn + 1 + WeightWidth;

    logic signed [ProdW-1:0]    prod;
    logic signed [WidthOut-1:0] acc;

    // Dot product of one window channel with one filter channel.
    always_comb begin
        prod = '0;
        acc  = '0;
        for (int k = 0; k < KernelArea; k++) begin
            prod = ProdW'($signed({1'b0, window_i[k]})) * ProdW'($signed(weights_i[k]));
            acc  = acc + WidthOut'(prod);
        end
    end

    assign sum_o = acc;

endmodule

// File: rtl/filter_seq.sv
// Sequential multi-output-channel convolution filter. One window is accepted
// per transaction; input channels are accumulated one per cycle for all
// output filters in parallel, then the result is held until handed off.
// Optional feature macro: FILTER_SATURATE_EN (clamping accumulation, sat_o).
module filter_seq
    import filter_pkg::*;
#(
    parameter int WidthIn     = 1,
    parameter int WidthOut    = 32,
    parameter int KernelWidth = 3,
    parameter int WeightWidth = 2,
    parameter int InChannels  = 1,
    parameter int OutChannels = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    filter_seq_if.slave  bus
);

    localparam int KernelArea = KernelWidth * KernelWidth;
    localparam int ChW        = (InChannels > 1) ? $clog2(InChannels) : 1;

    filter_state_e state_q, state_d;
    logic [ChW-1:0] ch_q, ch_d;
    logic [InChannels-1:0][KernelArea-1:0][WidthIn-1:0] window_q, window_d;
    logic signed [WidthOut-1:0] acc_q  [OutChannels];
    logic signed [WidthOut-1:0] acc_d  [OutChannels];
    logic signed [WidthOut-1:0] data_q [OutChannels];
    logic signed [WidthOut-1:0] data_d [OutChannels];
    logic signed [WidthOut-1:0] partial [OutChannels];

    logic ready;
    logic start;
    logic last_ch;

`ifdef FILTER_SATURATE_EN
    // sat_run collects clamp events of the running transaction; sat_q is the
    // flag published alongside the finished result.
    logic     sat_run_q, sat_run_d;
    logic     sat_q, sat_d;
    sat_res_t sat_r;
`endif

    // One MAC per output filter; the channel counter steers which window
    // channel and which weight slice are presented this cycle. Weights are
    // taken live from the bus, the window from the captured copy.
    for (genvar oc = 0; oc < OutChannels; oc++) begin : g_mac
        filter_seq_mac #(
            .WidthIn     (WidthIn),
            .WidthOut    (WidthOut),
            .KernelArea  (KernelArea),
            .WeightWidth (WeightWidth)
        ) u_mac (
            .window_i  (window_q[ch_q]),
            .weights_i (bus.weights_i[oc][ch_q]),
            .sum_o     (partial[oc])
        );
    end

    // Ready is purely state/downstream based so it never loops through valid.
    always_comb begin
        ready   = (state_q == IDLE) || ((state_q == DONE) && bus.ready_i);
        start   = bus.valid_i && ready;
        last_ch = (ch_q == ChW'(InChannels - 1));
    end

    // Next-state and datapath: accumulate in ACCUM, publish on the last channel.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        window_d = window_q;
        acc_d    = acc_q;
        data_d   = data_q;
`ifdef FILTER_SATURATE_EN
        sat_run_d = sat_run_q;
        sat_d     = sat_q;
        sat_r     = '0;
`endif
        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            ACCUM: begin
                for (int oc = 0; oc < OutChannels; oc++) begin
`ifdef FILTER_SATURATE_EN
                    sat_r     = sat_add(SatMaxWidth'(acc_q[oc]), SatMaxWidth'(partial[oc]), WidthOut);
                    acc_d[oc] = sat_r.sum[WidthOut-1:0];
                    sat_run_d = sat_run_d | sat_r.clamp;
`else
                    acc_d[oc] = acc_q[oc] + partial[oc];
`endif
                end
                ch_d = ch_q + 1'b1;
                if (last_ch) begin
                    state_d = DONE;
                    ch_d    = '0;
                    data_d  = acc_d;
`ifdef FILTER_SATURATE_EN
                    sat_d   = sat_run_d;
`endif
                end
            end
            DONE: begin
                if (bus.ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A new window (from IDLE, or back-to-back out of DONE) restarts the
        // accumulation from a clean slate.
        if (start) begin
            state_d  = ACCUM;
            ch_d     = '0;
            window_d = bus.windows_i;
            for (int oc = 0; oc < OutChannels; oc++) begin
                acc_d[oc] = '0;
            end
`ifdef FILTER_SATURATE_EN
            sat_run_d = 1'b0;
`endif
        end
    end

    // State and datapath registers; reset discards any transaction in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            window_q <= '0;
            for (int oc = 0; oc < OutChannels; oc++) begin
                acc_q[oc]  <= '0;
                data_q[oc] <= '0;
            end
`ifdef FILTER_SATURATE_EN
            sat_run_q <= 1'b0;
            sat_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            window_q <= window_d;
            for (int oc = 0; oc < OutChannels; oc++) begin
                acc_q[oc]  <= acc_d[oc];
                data_q[oc] <= data_d[oc];
            end
`ifdef FILTER_SATURATE_EN
            sat_run_q <= sat_run_d;
            sat_q     <= sat_d;
`endif
        end
    end

    // Outputs only ever show completed results held in data_q.
    always_comb begin
        bus.ready_o = ready;
        bus.valid_o = (state_q == DONE);
        bus.state_o = state_q;
        bus.data_o  = '0;
        for (int oc = 0; oc < OutChannels; oc++) begin
            bus.data_o[oc] = data_q[oc];
        end
`ifdef FILTER_SATURATE_EN
        bus.sat_o = sat_q;
`else
        bus.sat_o = 1'b0;
`endif
    end

endmodule

// File: tb/tb_filter_seq.sv
// Directed bench for filter_seq: a 2-in/2-out channel instance for the main
// behaviour and a 5-bit-output instance for wrap/saturation boundaries.
module tb_filter_seq;
    import filter_pkg::*;

    logic clk = 1'b0;
    logic rst;

    int n_vec  = 0;
    int n_miss = 0;
    logic [63:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    filter_seq_if #(.WidthIn(1), .WidthOut(32), .KernelWidth(3), .WeightWidth(2),
                    .InChannels(2), .OutChannels(2)) bus_a ();
    filter_seq_if #(.WidthIn(1), .WidthOut(5), .KernelWidth(3), .WeightWidth(2),
                    .InChannels(2), .OutChannels(1)) bus_b ();

    filter_seq #(.WidthIn(1), .WidthOut(32), .KernelWidth(3), .WeightWidth(2),
                 .InChannels(2), .OutChannels(2)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a)
    );

    filter_seq #(.WidthIn(1), .WidthOut(5), .KernelWidth(3), .WeightWidth(2),
                 .InChannels(2), .OutChannels(1)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b)
    );

`ifdef FILTER_SATURATE_EN
    localparam int ExpPos = 15;
    localparam int ExpPosSat = 1;
    localparam int ExpNeg = -16;
    localparam int ExpNegSat = 1;
`else
    localparam int ExpPos = -14;
    localparam int ExpPosSat = 0;
    localparam int ExpNeg = 14;
    localparam int ExpNegSat = 0;
`endif

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w_a(input logic [1:0] w00, input logic [1:0] w01,
                           input logic [1:0] w10, input logic [1:0] w11);
        for (int k = 0; k < 9; k++) begin
            bus_a.weights_i[0][0][k] = w00;
            bus_a.weights_i[0][1][k] = w01;
            bus_a.weights_i[1][0][k] = w10;
            bus_a.weights_i[1][1][k] = w11;
        end
    endtask

    // One transaction on dut_a; hold > 0 keeps ready_i low that many cycles in DONE.
    task automatic run_a(input string tag, input logic [17:0] win,
                         input int e0, input int e1, input int hold);
        int n;
        bus_a.windows_i = win;
        bus_a.valid_i   = 1'b1;
        bus_a.ready_i   = (hold == 0);
        check({tag, "_ready_idle"}, bus_a.ready_o, 1);
        cyc();
        bus_a.valid_i   = 1'b0;
        bus_a.windows_i = '0;
        check({tag, "_state_accum"}, bus_a.state_o, ACCUM);
        n = 0;
        while (!bus_a.valid_o && n < 10) begin
            cyc();
            n++;
        end
        check({tag, "_valid"}, bus_a.valid_o, 1);
        check({tag, "_latency"}, n, 2);
        check({tag, "_d0"}, $signed(bus_a.data_o[0]), e0);
        check({tag, "_d1"}, $signed(bus_a.data_o[1]), e1);
        if (hold > 0) begin
            check({tag, "_ready_held"}, bus_a.ready_o, 0);
            for (int i = 0; i < hold; i++) begin
                cyc();
                check({tag, "_hold_valid"}, bus_a.valid_o, 1);
                check({tag, "_hold_d0"}, $signed(bus_a.data_o[0]), e0);
                check({tag, "_hold_d1"}, $signed(bus_a.data_o[1]), e1);
            end
            bus_a.ready_i = 1'b1;
            #1;
            check({tag, "_ready_release"}, bus_a.ready_o, 1);
        end
        cyc();
        check({tag, "_state_idle"}, bus_a.state_o, IDLE);
        check({tag, "_valid_drop"}, bus_a.valid_o, 0);
    endtask

    // One transaction on dut_b with every weight set to w.
    task automatic run_b(input string tag, input logic [17:0] win, input logic [1:0] w,
                         input int e, input int esat);
        int n;
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < 9; k++)
                bus_b.weights_i[0][c][k] = w;
        bus_b.windows_i = win;
        bus_b.valid_i   = 1'b1;
        bus_b.ready_i   = 1'b1;
        cyc();
        bus_b.valid_i = 1'b0;
        n = 0;
        while (!bus_b.valid_o && n < 10) begin
            cyc();
            n++;
        end
        check({tag, "_valid"}, bus_b.valid_o, 1);
        check({tag, "_data"}, $signed(bus_b.data_o[0]), e);
        check({tag, "_sat"}, bus_b.sat_o, esat);
        cyc();
        check({tag, "_valid_drop"}, bus_b.valid_o, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [17:0] pats [3];
        logic [63:0] exps [3];
        logic [63:0] e;
        int idx, got, last_acc;
        logic acc, hs;

        rst = 1'b1;
        bus_a.valid_i = 1'b0; bus_a.ready_i = 1'b0; bus_a.windows_i = '0; bus_a.weights_i = '0;
        bus_b.valid_i = 1'b0; bus_b.ready_i = 1'b0; bus_b.windows_i = '0; bus_b.weights_i = '0;
        cyc();
        cyc();
        check("rst_state", bus_a.state_o, IDLE);
        check("rst_ready", bus_a.ready_o, 1);
        check("rst_valid", bus_a.valid_o, 0);
        check("rst_d0", $signed(bus_a.data_o[0]), 0);
        check("rst_d1", $signed(bus_a.data_o[1]), 0);
        check("rst_sat", bus_a.sat_o, 0);
        check("rst_b_data", $signed(bus_b.data_o[0]), 0);
        rst = 1'b0;
        cyc();

        // Ones with +1 weights, result held 5 cycles under backpressure.
        set_w_a(2'b01, 2'b01, 2'b01, 2'b01);
        run_a("ones_pos", '1, 18, 18, 5);

        // Second filter negated.
        set_w_a(2'b01, 2'b01, 2'b11, 2'b11);
        run_a("ones_neg", '1, 18, -18, 0);

        // Back-to-back stream: valid held high, one accept every 3 cycles.
        set_w_a(2'b01, 2'b01, 2'b01, 2'b11);
        pats[0] = '1;                            exps[0] = {32'(18), 32'(0)};
        pats[1] = {9'b000000000, 9'b111111111};  exps[1] = {32'(9), 32'(9)};
        pats[2] = {9'b000011111, 9'b000000111};  exps[2] = {32'(8), 32'(-2)};
        bus_a.windows_i = pats[0];
        bus_a.valid_i   = 1'b1;
        bus_a.ready_i   = 1'b1;
        idx = 0; got = 0; last_acc = -1;
        for (int c = 0; c < 40 && got < 3; c++) begin
            acc = bus_a.valid_i && bus_a.ready_o;
            hs  = bus_a.valid_o && bus_a.ready_i;
            if (hs) begin
                check("b2b_queue_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("b2b_d0", $signed(bus_a.data_o[0]), $signed(e[63:32]));
                    check("b2b_d1", $signed(bus_a.data_o[1]), $signed(e[31:0]));
                end
                got++;
            end
            if (acc) begin
                exp_q.push_back(exps[idx]);
                if (last_acc >= 0) check("b2b_gap", c - last_acc, 3);
                last_acc = c;
                idx++;
            end
            cyc();
            if (acc) begin
                if (idx < 3) bus_a.windows_i = pats[idx];
                else         bus_a.valid_i   = 1'b0;
            end
        end
        check("b2b_results", got, 3);
        check("b2b_queue_empty", exp_q.size(), 0);

        // Reset in the middle of ACCUM drops everything at once.
        bus_a.windows_i = '1;
        bus_a.valid_i   = 1'b1;
        cyc();
        bus_a.valid_i = 1'b0;
        check("arst_state_accum", bus_a.state_o, ACCUM);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", bus_a.valid_o, 0);
        check("arst_d0", $signed(bus_a.data_o[0]), 0);
        check("arst_d1", $signed(bus_a.data_o[1]), 0);
        check("arst_state", bus_a.state_o, IDLE);
        cyc();
        rst = 1'b0;
        cyc();
        run_a("post_rst", {9'b000000000, 9'b111111111}, 9, 9, 0);

        // 5-bit accumulator boundaries.
        run_b("w5_pos", '1, 2'b01, ExpPos, ExpPosSat);
        run_b("w5_neg", '1, 2'b11, ExpNeg, ExpNegSat);
        run_b("w5_fit", {9'b000000000, 9'b111111111}, 2'b01, 9, 0);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
